// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: FSM state encoding, checksum width
// and the running-checksum accumulate helper.
package boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHECK = 3'd3,
        ST_RUN   = 3'd4,
        ST_ERR   = 3'd5
    } boot_state_e;

    localparam int CSUM_W = 32;

    // Checksum is a plain modulo-2^CSUM_W sum of the program words.
    function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] acc,
                                                   input logic [31:0]       word);
        return acc + CSUM_W'(word);
    endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Valid/ready word stream feeding the boot loader.
interface boot_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;

    modport master (output in_valid, output in_data, input  in_ready);
    modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/boot_loader.sv
// Streams a length-prefixed, checksummed program into the core's memory and
// releases the core from reset only once the checksum has been verified.
module boot_loader
    import boot_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    boot_loader_if.slave s_in,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [31:0]  mem_wdata,
    output logic         core_rst_n,
    output logic         done,
    output logic         error
);

    localparam int          IDX_W     = $clog2(DEPTH_WORDS) + 1;
    localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_WORDS);

    boot_state_e       state_r;
    boot_state_e       state_s;
    logic [31:0]       len_r;
    logic [IDX_W-1:0]  idx_r;
    logic [CSUM_W-1:0] sum_r;
    logic              in_ready_r;
    logic              mem_we_r;
    logic [31:0]       mem_addr_r;
    logic [31:0]       mem_wdata_r;
    logic              core_rst_n_r;
    logic              done_r;
    logic              error_r;
    logic              xfer_s;
    logic [31:0]       idx_ext_s;
    logic              last_word_s;

    assign xfer_s      = s_in.in_valid & in_ready_r;
    assign idx_ext_s   = 32'(idx_r);
    assign last_word_s = ((idx_ext_s + 32'd1) == len_r);

    // Next-state decode; only accepted words advance the load.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: state_s = ST_LEN;
            ST_LEN: begin
                if (!xfer_s) begin
                    state_s = ST_LEN;
                end else if (s_in.in_data == 32'd0) begin
                    state_s = ST_CHECK;
                end else if (s_in.in_data > DEPTH_LIM) begin
                    state_s = ST_ERR;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_DATA: begin
                if (xfer_s && last_word_s) begin
                    state_s = ST_CHECK;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_CHECK: begin
                if (!xfer_s) begin
                    state_s = ST_CHECK;
                end else if (s_in.in_data == sum_r) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_ERR;
                end
            end
            ST_RUN:  state_s = ST_RUN;
            ST_ERR:  state_s = ST_ERR;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register plus status outputs registered from the next state,
    // so done/core_rst_n rise in the very first RUN cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            in_ready_r   <= 1'b0;
            core_rst_n_r <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            state_r      <= state_s;
            in_ready_r   <= (state_s == ST_LEN) || (state_s == ST_DATA) || (state_s == ST_CHECK);
            core_rst_n_r <= (state_s == ST_RUN);
            done_r       <= (state_s == ST_RUN);
            error_r      <= (state_s == ST_ERR);
        end
    end

    // Length latch, word index, running checksum and the one-cycle write strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_r       <= 32'd0;
            idx_r       <= '0;
            sum_r       <= '0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= 32'd0;
        end else if (xfer_s && (state_r == ST_LEN)) begin
            len_r    <= s_in.in_data;
            idx_r    <= '0;
            sum_r    <= '0;
            mem_we_r <= 1'b0;
        end else if (xfer_s && (state_r == ST_DATA)) begin
            idx_r       <= idx_r + IDX_W'(1);
            sum_r       <= csum_add(sum_r, s_in.in_data);
            mem_we_r    <= 1'b1;
            mem_addr_r  <= BASE_ADDR + (idx_ext_s << 2);
            mem_wdata_r <= s_in.in_data;
        end else begin
            mem_we_r <= 1'b0;
        end
    end

    assign s_in.in_ready = in_ready_r;
    assign mem_we        = mem_we_r;
    assign mem_addr      = mem_addr_r;
    assign mem_wdata     = mem_wdata_r;
    assign core_rst_n    = core_rst_n_r;
    assign done          = done_r;
    assign error         = error_r;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: table of load scenarios plus an
// abort-and-reload sequence; memory writes are matched against a scoreboard.
module tb_boot_loader;
    import boot_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] len;
        int          nsend;
        bit          use_lit;
        logic [31:0] cs_lit;
        logic [31:0] delta;
        bit          send_cs;
        bit          stall;
        bit          exp_done;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_rst_n;
    logic        done;
    logic        error;

    int          checks = 0;
    int          errors = 0;
    int          wr_count = 0;
    wr_t         sb_q[$];
    logic [31:0] last_addr = 32'd0;
    logic [31:0] last_data = 32'd0;
    logic [31:0] prog[256];
    vec_t        vecs[10];

    always #5 clk = ~clk;

    boot_loader_if bus ();

    boot_loader dut (
        .clk       (clk),
        .rst       (rst),
        .s_in      (bus),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_rst_n(core_rst_n),
        .done      (done),
        .error     (error)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    // Write monitor: pops the scoreboard on every strobe, checks hold otherwise.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                if (mem_we === 1'b1) begin
                    chk1("core_rst_n_during_write", core_rst_n, 1'b0);
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got addr %h data %h, expected no write",
                                 mem_addr, mem_wdata);
                    end else begin
                        e = sb_q.pop_front();
                        chk("wr_addr", mem_addr, e.addr);
                        chk("wr_data", mem_wdata, e.data);
                    end
                    wr_count++;
                    last_addr = mem_addr;
                    last_data = mem_wdata;
                end else begin
                    chk("hold_addr", mem_addr, last_addr);
                    chk("hold_data", mem_wdata, last_data);
                end
            end
        end
    end

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        last_addr = 32'd0;
        last_data = 32'd0;
        wr_count  = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk1("idle_ready", bus.in_ready, 1'b0);
        @(negedge clk);
        chk1("len_ready", bus.in_ready, 1'b1);
    endtask

    task automatic send_word(input logic [31:0] w, input int stall);
        logic rdy;
        bit   ok;
        ok = 1'b0;
        repeat (stall) begin
            bus.in_valid = 1'b0;
            bus.in_data  = $urandom();
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        for (int t = 0; t < 16 && !ok; t++) begin
            rdy = bus.in_ready;
            @(negedge clk);
            if (rdy === 1'b1) ok = 1'b1;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom();
        chk1("send_accept", ok, 1'b1);
    endtask

    task automatic run_vec(input int id, input vec_t v);
        logic [CSUM_W-1:0] sum;
        logic [31:0]       cs;
        string             tag;
        tag = $sformatf("vec%0d", id);
        do_reset();
        send_word(v.len, v.stall ? int'($urandom_range(0, 5)) : 0);
        if (v.len > 32'd256) chk1({tag, "_err_after_len"}, error, 1'b1);
        sum = '0;
        for (int i = 0; i < v.nsend; i++) begin
            sb_q.push_back('{addr: 32'(i) << 2, data: prog[i]});
            sum = sum + prog[i];
            send_word(prog[i], v.stall ? int'($urandom_range(0, 5)) : 0);
        end
        if (v.send_cs) begin
            cs = v.use_lit ? v.cs_lit : (sum + v.delta);
            send_word(cs, v.stall ? int'($urandom_range(0, 5)) : 0);
            chk1({tag, "_done_next"}, done, v.exp_done);
            chk1({tag, "_error_next"}, error, !v.exp_done);
            chk1({tag, "_core_rst_next"}, core_rst_n, v.exp_done);
        end
        repeat (3) @(negedge clk);
        chk1({tag, "_done"}, done, v.exp_done);
        chk1({tag, "_error"}, error, !v.exp_done);
        chk1({tag, "_core_rst_n"}, core_rst_n, v.exp_done);
        chk1({tag, "_ready_off"}, bus.in_ready, 1'b0);
        chk({tag, "_wr_count"}, 32'(wr_count), 32'(v.nsend));
        chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        prog[0] = 32'h0050_0113;
        prog[1] = 32'h00C0_0193;
        prog[2] = 32'h0031_00B3;
        for (int i = 3; i < 256; i++) prog[i] = 32'(i) * 32'h9E37_79B1;

        //             len            n    lit   cs_lit         delta  cs    stall done
        vecs[0] = '{32'd3,          3,   1'b0, 32'd0,         32'd0, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{32'd3,          3,   1'b1, 32'h00E1_0308, 32'd0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'd3,          3,   1'b0, 32'd0,         32'd1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{32'd257,        0,   1'b0, 32'd0,         32'd0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{32'd0,          0,   1'b0, 32'd0,         32'd0, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{32'd0,          0,   1'b0, 32'd0,         32'd1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{32'd16,         16,  1'b0, 32'd0,         32'd0, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{32'd16,         16,  1'b0, 32'd0,         32'd0, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{32'd256,        256, 1'b0, 32'd0,         32'd0, 1'b1, 1'b0, 1'b1};
        vecs[9] = '{32'hFFFF_FFFF,  0,   1'b0, 32'd0,         32'd0, 1'b0, 1'b0, 1'b0};

        bus.in_valid = 1'b0;
        bus.in_data  = 32'd0;
        rst = 1'b0;
        #1;
        chk1("rst_in_ready", bus.in_ready, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk1("rst_core_rst_n", core_rst_n, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_error", error, 1'b0);

        for (int k = 0; k < 10; k++) run_vec(k, vecs[k]);

        // Abort after two data words, then reload the full stream.
        do_reset();
        send_word(32'd3, 0);
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back('{addr: 32'(i) << 2, data: prog[i]});
            send_word(prog[i], 0);
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        last_addr = 32'd0;
        last_data = 32'd0;
        #1;
        chk1("abort_core_rst_n", core_rst_n, 1'b0);
        chk1("abort_in_ready", bus.in_ready, 1'b0);
        chk1("abort_mem_we", mem_we, 1'b0);
        chk("abort_mem_addr", mem_addr, 32'd0);
        chk("abort_wr_count", 32'(wr_count), 32'd2);
        chk("abort_sb_empty", 32'(sb_q.size()), 32'd0);
        run_vec(10, vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
